instruction_queue: RTL and testbench

// - Decoupling FIFO between the control unit (producer: memory/processing instruction writes) and the cherry core (consumer).
// - Stores each instruction with its superscalar copy_count and presents it to the core through a valid/ready handshake.
// - Drives queue_almost_full back to the control unit early enough that its stall decision never causes an overflow.
// - Two instances sit in the design: one for memory instructions, one for processing instructions.

---
 rtl/instruction_queue_pkg.sv | 14 +
 rtl/instruction_queue_ram.sv | 23 ++
 rtl/instruction_queue.sv | 96 +++++++++
 tb/tb_instruction_queue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_queue_pkg.sv
// Shared cherry queue types and defaults used by the instruction queues.
package instruction_queue_pkg;

  localparam int IQ_DEFAULT_WIDTH          = 64;
  localparam int IQ_DEFAULT_SSLW           = 2;
  localparam int IQ_DEFAULT_LOG_DEPTH      = 5;
  localparam int IQ_MIN_ALMOST_FULL_MARGIN = 3;

  typedef struct packed {
    logic [IQ_DEFAULT_WIDTH-1:0] payload;
    logic [IQ_DEFAULT_SSLW-1:0]  copy_count;
  } queue_entry_t;

endpackage

// File: rtl/instruction_queue_ram.sv
// Simple dual-port queue body: one write port, one registered read port.
// The read register doubles as the queue's output register (holds when re=0).
module queue_ram #(
  parameter int W         = 66,
  parameter int LOG_DEPTH = 5
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [LOG_DEPTH-1:0] waddr,
  input  logic [W-1:0]         wdata,
  input  logic                 re,
  input  logic [LOG_DEPTH-1:0] raddr,
  output logic [W-1:0]         rdata
);

  logic [W-1:0] mem [2**LOG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instruction_queue.sv
// Decoupling FIFO between control unit and cherry core; RAM body plus output
// register with valid/ready, registered almost_full/full and sticky overflow.
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int WIDTH                 = IQ_DEFAULT_WIDTH,
  parameter int SUPERSCALAR_LOG_WIDTH = IQ_DEFAULT_SSLW,
  parameter int LOG_DEPTH             = IQ_DEFAULT_LOG_DEPTH,
  parameter int ALMOST_FULL_MARGIN    = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             we,
  input  logic [WIDTH-1:0]                 wdata,
  input  logic [SUPERSCALAR_LOG_WIDTH-1:0] wcopy_count,
  output logic                             almost_full,
  output logic                             full,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic [SUPERSCALAR_LOG_WIDTH-1:0] out_copy_count,
  output logic [LOG_DEPTH:0]               count,
  output logic                             overflow
);

  localparam int DEPTH = 2**LOG_DEPTH;
  localparam int EW    = WIDTH + SUPERSCALAR_LOG_WIDTH;
  localparam logic [LOG_DEPTH:0] AF_LEVEL   = (LOG_DEPTH+1)'(DEPTH - ALMOST_FULL_MARGIN);
  localparam logic [LOG_DEPTH:0] FULL_LEVEL = (LOG_DEPTH+1)'(DEPTH);

  // The producer needs three cycles to react to almost_full.
  if (ALMOST_FULL_MARGIN < IQ_MIN_ALMOST_FULL_MARGIN) begin : g_margin_check
    $error("instruction_queue: ALMOST_FULL_MARGIN must be >= 3");
  end

  typedef struct packed {
    logic [WIDTH-1:0]                 payload;
    logic [SUPERSCALAR_LOG_WIDTH-1:0] copy_count;
  } entry_t;

  entry_t               wentry, rentry;
  logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [LOG_DEPTH:0]   ram_count, count_next;
  logic                 pop, push, load, ram_we, ram_re;

  always_comb begin
    pop        = out_valid && out_ready;
    push       = we && (!full || pop);
    // Entries still in the RAM body, i.e. not yet in the output register.
    ram_count  = count - (LOG_DEPTH+1)'(out_valid);
    load       = (!out_valid || pop) && (ram_count != '0);
    count_next = count + (LOG_DEPTH+1)'(push) - (LOG_DEPTH+1)'(pop);
    ram_we     = push && !flush && !reset;
    ram_re     = load && !flush && !reset;
    wentry     = '{payload: wdata, copy_count: wcopy_count};
  end

  queue_ram #(.W(EW), .LOG_DEPTH(LOG_DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (wentry),
    .re    (ram_re),
    .raddr (rd_ptr),
    .rdata (rentry)
  );

  assign out_data       = rentry.payload;
  assign out_copy_count = rentry.copy_count;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      almost_full <= 1'b0;
      full        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LOG_DEPTH'(1);
      if (load) rd_ptr <= rd_ptr + LOG_DEPTH'(1);
      count       <= count_next;
      out_valid   <= load || (out_valid && !pop);
      almost_full <= count_next >= AF_LEVEL;
      full        <= count_next == FULL_LEVEL;
    end
  end

  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) overflow <= 1'b0;
    else if (!flush && we && full && !pop) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: latency, fill/overflow, streaming,
// random backpressure with scoreboard, flush and reset.
module tb_instruction_queue;
  import instruction_queue_pkg::*;

  localparam int W = 64, SSLW = 2, LD = 5, DEPTH = 32;

  logic            clk = 1'b0;
  logic            reset, flush, we, out_ready;
  logic [W-1:0]    wdata;
  logic [SSLW-1:0] wcopy_count;
  logic            almost_full, full, out_valid, overflow;
  logic [W-1:0]    out_data;
  logic [SSLW-1:0] out_copy_count;
  logic [LD:0]     count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_queue #(
    .WIDTH(W), .SUPERSCALAR_LOG_WIDTH(SSLW), .LOG_DEPTH(LD), .ALMOST_FULL_MARGIN(4)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .we(we), .wdata(wdata),
    .wcopy_count(wcopy_count), .almost_full(almost_full), .full(full),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_copy_count(out_copy_count), .count(count), .overflow(overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; we = 1'b0; out_ready = 1'b0;
    wdata = '0; wcopy_count = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %0b expected 0", almost_full); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %0b expected 0", out_valid); end
  endtask

  task automatic test_single_push();
    we = 1'b1; wdata = 64'hA5; wcopy_count = 2'd2;
    step();
    we = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_n1: got %0b expected 0", out_valid); end
    checks++; if (count !== 6'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid_n2: got %0b expected 1", out_valid); end
    checks++; if (out_data !== 64'hA5) begin errors++; $display("FAIL single_data: got %0h expected a5", out_data); end
    checks++; if (out_copy_count !== 2'd2) begin errors++; $display("FAIL single_copy: got %0d expected 2", out_copy_count); end
    step();
    checks++; if (out_data !== 64'hA5 || out_valid !== 1'b1) begin errors++; $display("FAIL single_hold: got %0h/%0b expected a5/1", out_data, out_valid); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || count !== 6'd0) begin errors++; $display("FAIL single_pop: got valid %0b count %0d expected 0/0", out_valid, count); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      we = 1'b1; wdata = 64'(i); wcopy_count = 2'(i);
      step();
      if (i == 27) begin
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL fill_af_27: got %0b expected 0", almost_full); end
      end
      if (i == 28) begin
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL fill_af_28: got %0b expected 1", almost_full); end
      end
      if (i == 31) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full_31: got %0b expected 0", full); end
      end
    end
    checks++; if (full !== 1'b1 || count !== 6'd32) begin errors++; $display("FAIL fill_full_32: got full %0b count %0d expected 1/32", full, count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_overflow: got %0b expected 0", overflow); end
    wdata = 64'hDEAD;
    step();
    we = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %0b expected 1", overflow); end
    checks++; if (count !== 6'd32) begin errors++; $display("FAIL overflow_count: got %0d expected 32", count); end
    checks++; if (out_data !== 64'd1) begin errors++; $display("FAIL overflow_head: got %0d expected 1", out_data); end
  endtask

  task automatic test_full_push_pop();
    logic [W-1:0] exp;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      we = 1'b1; wdata = 64'(100 + i); wcopy_count = 2'(i);
      step();
    end
    wdata = 64'd200; wcopy_count = 2'd3; out_ready = 1'b1;
    step();
    we = 1'b0;
    checks++; if (count !== 6'd32) begin errors++; $display("FAIL fpp_count: got %0d expected 32", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow: got %0b expected 0", overflow); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fpp_full: got %0b expected 1", full); end
    for (int i = 1; i <= DEPTH; i++) begin
      exp = (i == DEPTH) ? 64'd200 : 64'(100 + i);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++; $display("FAIL fpp_drain[%0d]: got %0d valid %0b expected %0d", i, out_data, out_valid, exp);
      end
      step();
    end
    out_ready = 1'b0;
    checks++; if (count !== 6'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: got count %0d valid %0b expected 0/0", count, out_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 104; c++) begin
      we = (c < 100);
      wdata = 64'(1000 + c);
      wcopy_count = 2'(c);
      step();
      checks++;
      if (c >= 1 && c <= 100) begin
        if (out_valid !== 1'b1 || out_data !== 64'(1000 + c - 1) || out_copy_count !== 2'(c - 1)) begin
          errors++; $display("FAIL stream[%0d]: got %0d/%0d valid %0b expected %0d/%0d", c - 1, out_data, out_copy_count, out_valid, 1000 + c - 1, (c - 1) % 4);
        end
      end else if (out_valid !== 1'b0) begin
        errors++; $display("FAIL stream_idle[%0d]: got valid %0b expected 0", c, out_valid);
      end
    end
    we = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    queue_entry_t sb[$];
    queue_entry_t e;
    int pushed = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    do_reset();
    while ((pushed < 150 || sb.size() != 0) && cyc < 6000) begin
      out_ready = ($urandom_range(0, 99) < 60);
      we = (pushed < 150) && !full && ($urandom_range(0, 99) < 55);
      wdata = 64'(5000 + pushed);
      wcopy_count = 2'(pushed * 3);
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++; $display("FAIL bp_stable: got %0d valid %0b expected %0d", out_data, out_valid, prev_data);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL bp_unexpected_pop: got %0d expected none", out_data);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.payload || out_copy_count !== e.copy_count) begin
            errors++; $display("FAIL bp_data: got %0d/%0d expected %0d/%0d", out_data, out_copy_count, e.payload, e.copy_count);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (we) begin
        sb.push_back('{payload: wdata, copy_count: wcopy_count});
        pushed++;
      end
      step();
      cyc++;
      checks++;
      if (count !== 6'(sb.size())) begin
        errors++; $display("FAIL bp_count: got %0d expected %0d", count, sb.size());
      end
    end
    we = 1'b0; out_ready = 1'b0;
    checks++;
    if (cyc >= 6000) begin errors++; $display("FAIL bp_timeout: got %0d left expected 0", sb.size()); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow: got %0b expected 0", overflow); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      we = 1'b1; wdata = 64'(i); wcopy_count = 2'd0;
      step();
    end
    we = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 22; i++) step();
    out_ready = 1'b0;
    checks++; if (count !== 6'd10 || overflow !== 1'b1) begin errors++; $display("FAIL flush_pre: got count %0d ovf %0b expected 10/1", count, overflow); end
    flush = 1'b1; we = 1'b1; wdata = 64'h77; out_ready = 1'b1;
    step();
    flush = 1'b0; we = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b expected 0", out_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_overflow_kept: got %0b expected 1", overflow); end
    checks++; if (almost_full !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL flush_flags: got af %0b full %0b expected 0/0", almost_full, full); end
    step(); step();
    checks++; if (out_valid !== 1'b0 || count !== 6'd0) begin errors++; $display("FAIL flush_no_ghost: got valid %0b count %0d expected 0/0", out_valid, count); end
    do_reset();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_clears_overflow: got %0b expected 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_overflow();
    test_full_push_pop();
    test_stream();
    test_backpressure();
    test_flush_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
